// File: rtl/afu_mmio_prmgmt_bridge.sv
// MMIO-to-prmgmt bridge: decodes CCI-P MMIO accesses into a small AFU register
// file and turns CTRL writes into single prmgmt transactions with ack/timeout.
module afu_mmio_prmgmt_bridge #(
   parameter logic [63:0] AFU_ID_L    = 64'h0,
   parameter logic [63:0] AFU_ID_H    = 64'h0,
   parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_0001,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic        i_pClk,
   input  logic        i_pck_cp2af_softReset,
   input  logic        i_mmio_rd_valid,
   input  logic        i_mmio_wr_valid,
   input  logic [15:0] i_mmio_addr,
   input  logic [1:0]  i_mmio_len,
   input  logic [8:0]  i_mmio_tid,
   input  logic [63:0] i_mmio_wdata,
   output logic        o_mmio_rsp_valid,
   output logic [8:0]  o_mmio_rsp_tid,
   output logic [63:0] o_mmio_rsp_data,
   output logic [1:0]  o_prmgmt_cmd,
   output logic [15:0] o_prmgmt_addr,
   output logic [31:0] o_prmgmt_din,
   input  logic [31:0] i_prmgmt_dout,
   input  logic        i_prmgmt_ack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
   localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_ctrl_addr;
   logic        r_ctrl_wr;
   logic        r_ctrl_rd;
   logic        r_illegal;
   logic        r_timeout;
   logic        r_done;
   logic        r_busy;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [63:0] r_scratch;
   logic [15:0] r_cnt;

   logic [1:0]  r_pm_cmd;
   logic [15:0] r_pm_addr;
   logic [31:0] r_pm_din;

   logic        r_rd1_valid;
   logic [8:0]  r_rd1_tid;
   logic [63:0] r_rd1_data;
   logic        r_rsp_valid;
   logic [8:0]  r_rsp_tid;
   logic [63:0] r_rsp_data;

   logic [14:0] w_idx;
   logic        w_is_wr;
   logic        w_ctrl_wr;
   logic        w_rise_wr;
   logic        w_rise_rd;
   logic        w_launch;
   logic        w_illegal_set;
   logic        w_tmo_hit;
   logic [63:0] w_rd_reg;
   logic [63:0] w_rd_data;

   assign w_idx     = i_mmio_addr[15:1];
   assign w_is_wr   = i_mmio_wr_valid & (i_mmio_len == 2'b10);
   assign w_ctrl_wr = w_is_wr & (w_idx == 15'd6);
   assign w_tmo_hit = (r_cnt == TMO_LAST);

   // Launch decode: only a 0->1 edge of exactly one command bit from IDLE starts a transaction
   always_comb begin
      w_rise_wr     = w_ctrl_wr & i_mmio_wdata[16] & ~r_ctrl_wr;
      w_rise_rd     = w_ctrl_wr & i_mmio_wdata[17] & ~r_ctrl_rd;
      w_launch      = 1'b0;
      w_illegal_set = 1'b0;
      if (w_rise_wr || w_rise_rd) begin
         if ((w_rise_wr && w_rise_rd) || (r_state != ST_IDLE)) begin
            w_illegal_set = 1'b1;
         end else begin
            w_launch = 1'b1;
         end
      end else begin
         w_launch      = 1'b0;
         w_illegal_set = 1'b0;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_launch) begin
               w_state_nxt = ST_WAIT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (i_prmgmt_ack || w_tmo_hit) begin
               w_state_nxt = ST_DONE;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge i_pClk) begin
      if (i_pck_cp2af_softReset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Register file, status bits and prmgmt transaction outputs
   always_ff @(posedge i_pClk) begin
      if (i_pck_cp2af_softReset) begin
         r_ctrl_addr <= 16'h0;
         r_ctrl_wr   <= 1'b0;
         r_ctrl_rd   <= 1'b0;
         r_illegal   <= 1'b0;
         r_timeout   <= 1'b0;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
         r_wdata     <= 32'h0;
         r_rdata     <= 32'h0;
         r_scratch   <= 64'h0;
         r_cnt       <= 16'h0;
         r_pm_cmd    <= 2'b00;
         r_pm_addr   <= 16'h0;
         r_pm_din    <= 32'h0;
      end else begin
         if (w_is_wr) begin
            case (w_idx)
               15'd6: begin
                  r_ctrl_addr <= i_mmio_wdata[15:0];
                  r_ctrl_wr   <= i_mmio_wdata[16];
                  r_ctrl_rd   <= i_mmio_wdata[17];
               end
               15'd7:   r_wdata   <= i_mmio_wdata[31:0];
               15'd9:   r_scratch <= i_mmio_wdata;
               default: ;
            endcase
         end

         if (w_launch) begin
            r_illegal <= 1'b0;
         end else if (w_illegal_set) begin
            r_illegal <= 1'b1;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_launch) begin
                  r_pm_addr <= i_mmio_wdata[15:0];
                  r_pm_din  <= r_wdata;
                  r_pm_cmd  <= {w_rise_rd, w_rise_wr};
                  r_busy    <= 1'b1;
                  r_done    <= 1'b0;
                  r_timeout <= 1'b0;
                  r_cnt     <= 16'h0;
               end
            end
            ST_WAIT: begin
               // ack has priority over a timeout landing on the same cycle
               if (i_prmgmt_ack) begin
                  if (r_pm_cmd[1]) begin
                     r_rdata <= i_prmgmt_dout;
                  end
                  r_pm_cmd <= 2'b00;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
               end else if (w_tmo_hit) begin
                  r_rdata   <= TMO_DATA;
                  r_timeout <= 1'b1;
                  r_pm_cmd  <= 2'b00;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            ST_DONE: ;
            default: r_pm_cmd <= 2'b00;
         endcase
      end
   end

   // Read decode sees pre-update register values
   always_comb begin
      w_rd_reg = 64'h0;
      case (w_idx)
         15'd0:   w_rd_reg = DFH_VALUE;
         15'd1:   w_rd_reg = AFU_ID_L;
         15'd2:   w_rd_reg = AFU_ID_H;
         15'd6:   w_rd_reg = {32'h0, r_busy, r_done, r_timeout, r_illegal, 10'h0,
                              r_ctrl_rd, r_ctrl_wr, r_ctrl_addr};
         15'd7:   w_rd_reg = {32'h0, r_wdata};
         15'd8:   w_rd_reg = {32'h0, r_rdata};
         15'd9:   w_rd_reg = r_scratch;
         default: w_rd_reg = 64'h0;
      endcase
   end

   // 32-bit reads return the addressed half in the low word
   always_comb begin
      w_rd_data = 64'h0;
      if (i_mmio_len == 2'b10) begin
         w_rd_data = w_rd_reg;
      end else if (i_mmio_addr[0]) begin
         w_rd_data = {32'h0, w_rd_reg[63:32]};
      end else begin
         w_rd_data = {32'h0, w_rd_reg[31:0]};
      end
   end

   // Two-stage read response pipeline
   always_ff @(posedge i_pClk) begin
      if (i_pck_cp2af_softReset) begin
         r_rd1_valid <= 1'b0;
         r_rd1_tid   <= 9'h0;
         r_rd1_data  <= 64'h0;
         r_rsp_valid <= 1'b0;
         r_rsp_tid   <= 9'h0;
         r_rsp_data  <= 64'h0;
      end else begin
         r_rd1_valid <= i_mmio_rd_valid;
         if (i_mmio_rd_valid) begin
            r_rd1_tid  <= i_mmio_tid;
            r_rd1_data <= w_rd_data;
         end
         r_rsp_valid <= r_rd1_valid;
         if (r_rd1_valid) begin
            r_rsp_tid  <= r_rd1_tid;
            r_rsp_data <= r_rd1_data;
         end
      end
   end

   assign o_mmio_rsp_valid = r_rsp_valid;
   assign o_mmio_rsp_tid   = r_rsp_tid;
   assign o_mmio_rsp_data  = r_rsp_data;
   assign o_prmgmt_cmd     = r_pm_cmd;
   assign o_prmgmt_addr    = r_pm_addr;
   assign o_prmgmt_din     = r_pm_din;

endmodule
